// File: rtl/avg_unpool_layer.sv
// 2x2 average-unpool / nearest-neighbour upsample stage.
// Buffers one pooled row, then emits it twice, with each sample duplicated horizontally.
module avg_unpool_layer #(
    parameter int DATA_W = 32,
    parameter int IN_W   = 3,
    parameter int IN_H   = 3,
    parameter int MODE   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int ICW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int OCW = $clog2(2 * IN_W);
    localparam int IRW = (IN_H > 1) ? $clog2(IN_H) : 1;

    localparam logic [ICW-1:0] ICOL_MAX = ICW'(IN_W - 1);
    localparam logic [OCW-1:0] OCOL_MAX = OCW'(2 * IN_W - 1);
    localparam logic [IRW-1:0] IROW_MAX = IRW'(IN_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_EMIT0,
        S_EMIT1,
        S_FIN
    } state_t;

    state_t r_state, w_state_nxt;

    logic [ICW-1:0] r_icol, w_icol_nxt;
    logic [OCW-1:0] r_ocol, w_ocol_nxt;
    logic [IRW-1:0] r_irow, w_irow_nxt;

    logic signed [DATA_W-1:0] r_rowbuf [IN_W];
    logic signed [DATA_W-1:0] r_out_data;
    logic                     r_out_last;

    logic                     w_acc_in;
    logic                     w_acc_out;
    logic                     w_load;
    logic [ICW-1:0]           w_idx;
    logic signed [DATA_W-1:0] w_src;
    logic signed [DATA_W-1:0] w_scaled;

    assign w_acc_in  = (r_state == S_FILL) && in_valid;
    assign w_acc_out = ((r_state == S_EMIT0) || (r_state == S_EMIT1)) && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_icol_nxt  = r_icol;
        w_ocol_nxt  = r_ocol;
        w_irow_nxt  = r_irow;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FILL;
                    w_icol_nxt  = '0;
                    w_ocol_nxt  = '0;
                    w_irow_nxt  = '0;
                end
            end
            S_FILL: begin
                if (in_valid) begin
                    if (r_icol == ICOL_MAX) begin
                        w_icol_nxt  = '0;
                        w_ocol_nxt  = '0;
                        w_state_nxt = S_EMIT0;
                    end else begin
                        w_icol_nxt = r_icol + 1'b1;
                    end
                end
            end
            S_EMIT0: begin
                if (out_ready) begin
                    if (r_ocol == OCOL_MAX) begin
                        w_ocol_nxt  = '0;
                        w_state_nxt = S_EMIT1;
                    end else begin
                        w_ocol_nxt = r_ocol + 1'b1;
                    end
                end
            end
            S_EMIT1: begin
                if (out_ready) begin
                    if (r_ocol == OCOL_MAX) begin
                        w_ocol_nxt = '0;
                        if (r_irow == IROW_MAX) begin
                            w_state_nxt = S_FIN;
                        end else begin
                            w_irow_nxt  = r_irow + 1'b1;
                            w_state_nxt = S_FILL;
                        end
                    end else begin
                        w_ocol_nxt = r_ocol + 1'b1;
                    end
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
                w_irow_nxt  = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_icol  <= '0;
            r_ocol  <= '0;
            r_irow  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_icol  <= w_icol_nxt;
            r_ocol  <= w_ocol_nxt;
            r_irow  <= w_irow_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc_in) begin
            r_rowbuf[r_icol] <= in_data;
        end
    end

    // Output register is preloaded with the sample for the next beat; the bypass covers
    // the row's final input beat landing in the same slot that is about to be read.
    assign w_idx    = ICW'(w_ocol_nxt >> 1);
    assign w_src    = (w_acc_in && (w_idx == r_icol)) ? in_data : r_rowbuf[w_idx];
    assign w_scaled = (MODE == 0) ? (w_src >>> 2) : w_src;
    assign w_load   = ((w_state_nxt == S_EMIT0) || (w_state_nxt == S_EMIT1))
                      && (w_acc_in || w_acc_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else if (w_load) begin
            r_out_data <= w_scaled;
            r_out_last <= (w_state_nxt == S_EMIT1) && (w_irow_nxt == IROW_MAX)
                          && (w_ocol_nxt == OCOL_MAX);
        end else if ((w_state_nxt != S_EMIT0) && (w_state_nxt != S_EMIT1)) begin
            r_out_last <= 1'b0;
        end
    end

    assign in_ready  = (r_state == S_FILL);
    assign out_valid = (r_state == S_EMIT0) || (r_state == S_EMIT1);
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);

endmodule
